demux_param: RTL and testbench



---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_slot.sv | 35 +++
 rtl/demux_param.sv | 82 ++++++++
 tb/tb_demux_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and elaboration helpers for the parameterised demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_NUM_OUTPUT_DEF = 32'd15;
    localparam int unsigned DEMUX_SEL_WIDTH_DEF  = 32'd4;
    localparam int unsigned DEMUX_DATA_WIDTH_DEF = 32'd4;

    // Smallest select width able to address n slots (at least one bit).
    function automatic int unsigned demux_min_sel_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output slot of the demultiplexer: data register plus valid flag, both cleared unless loaded.
import demux_pkg::*;

module demux_slot #(
    parameter int unsigned DATA_WIDTH = DEMUX_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;

    // Slot register: a non-selected cycle returns the slot to zero, there is no hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load_en) begin
            data_r  <= data_in;
            valid_r <= 1'b1;
        end else begin
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end
    end

    assign data_out  = data_r;
    assign valid_out = valid_r;

endmodule

// File: rtl/demux_param.sv
// Registered 1-to-N demultiplexer with one-hot valid strobe.
// Optional macro DEMUX_SEL_ERR_EN adds a registered sel_err flag for out-of-range selects.
import demux_pkg::*;

module demux_param #(
    parameter int unsigned NUM_OUTPUT = DEMUX_NUM_OUTPUT_DEF,
    parameter int unsigned SEL_WIDTH  = DEMUX_SEL_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DEMUX_DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [SEL_WIDTH-1:0]             sel,
`ifdef DEMUX_SEL_ERR_EN
    output logic                             sel_err,
`endif
    output logic [DATA_WIDTH*NUM_OUTPUT-1:0] data_out,
    output logic [NUM_OUTPUT-1:0]            valid_out
);

    localparam logic [SEL_WIDTH:0] NUM_OUTPUT_L = (SEL_WIDTH + 1)'(NUM_OUTPUT);

    generate
        if (NUM_OUTPUT < 32'd2) begin : g_bad_num
            $error("demux_param: NUM_OUTPUT must be at least 2");
        end else if (SEL_WIDTH < demux_min_sel_width(NUM_OUTPUT)) begin : g_bad_sel
            $error("demux_param: SEL_WIDTH too narrow for NUM_OUTPUT");
        end else begin : g_cfg_ok
        end
    endgenerate

    logic                  in_range_s;
    logic                  route_s;
    logic [NUM_OUTPUT-1:0] load_en_s;

    // Range check: the extra top bit keeps the compare exact when NUM_OUTPUT == 2**SEL_WIDTH.
    always_comb begin
        in_range_s = 1'b0;
        if ({1'b0, sel} < NUM_OUTPUT_L) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end

    assign route_s = valid_in & in_range_s;

    genvar j;
    generate
        for (j = 0; j < NUM_OUTPUT; j++) begin : g_slot
            assign load_en_s[j] = route_s & (sel == SEL_WIDTH'(j));

            demux_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load_en   (load_en_s[j]),
                .data_in   (data_in),
                .data_out  (data_out[j*DATA_WIDTH +: DATA_WIDTH]),
                .valid_out (valid_out[j])
            );
        end
    endgenerate

`ifdef DEMUX_SEL_ERR_EN
    logic sel_err_r;

    // Error strobe aligned with the data path: one cycle per dropped valid word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= valid_in & ~in_range_s;
        end
    end

    assign sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_demux_param.sv
// Directed self-checking bench for demux_param with default parameters.
module tb_demux_param;

    localparam int NO = 15;
    localparam int SW = 4;
    localparam int DW = 4;

    logic               clk;
    logic               rst_n;
    logic               valid_in;
    logic [DW-1:0]      data_in;
    logic [SW-1:0]      sel;
    logic [DW*NO-1:0]   data_out;
    logic [NO-1:0]      valid_out;
`ifdef DEMUX_SEL_ERR_EN
    logic               sel_err;
`endif

    int checks_cnt;
    int fail_cnt;

    demux_param #(
        .NUM_OUTPUT (NO),
        .SEL_WIDTH  (SW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sel       (sel),
`ifdef DEMUX_SEL_ERR_EN
        .sel_err   (sel_err),
`endif
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s);
        valid_in = v;
        data_in  = d;
        sel      = s;
    endtask

    initial begin
        logic [63:0] exp_data;
        logic [63:0] exp_valid;
        checks_cnt = 0;
        fail_cnt   = 0;

        // Reset held with live stimulus
        rst_n = 1'b0;
        drive(1'b1, 4'hA, 4'd2);
        step();
        step();
        check("rst_data", 64'(data_out), 64'h0);
        check("rst_valid", 64'(valid_out), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
        check("rst_selerr", 64'(sel_err), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_data", 64'(data_out), 64'h0000_0000_0000_0A00);
        check("rel_valid", 64'(valid_out), 64'h0004);

        // Sweep every slot with 4'hA
        for (int i = 0; i < NO; i++) begin
            drive(1'b1, 4'hA, SW'(i));
            step();
            exp_data  = 64'hA << (4 * i);
            exp_valid = 64'h1 << i;
            check($sformatf("sweep_data%0d", i), 64'(data_out), exp_data);
            check($sformatf("sweep_valid%0d", i), 64'(valid_out), exp_valid);
        end

        // Boundary slots with other patterns
        drive(1'b1, 4'h5, 4'd14);
        step();
        check("top_data", 64'(data_out), 64'h0500_0000_0000_0000);
        check("top_valid", 64'(valid_out), 64'h4000);
        drive(1'b1, 4'hF, 4'd0);
        step();
        check("bot_data", 64'(data_out), 64'h0000_0000_0000_000F);
        check("bot_valid", 64'(valid_out), 64'h0001);

        // Back-to-back select change
        drive(1'b1, 4'hA, 4'd3);
        step();
        check("b2b3_data", 64'(data_out), 64'h0000_0000_0000_A000);
        drive(1'b1, 4'hA, 4'd7);
        step();
        check("b2b7_data", 64'(data_out), 64'h0000_0000_A000_0000);
        check("b2b7_valid", 64'(valid_out), 64'h0080);

        // Out-of-range select
        drive(1'b1, 4'hA, 4'd15);
        step();
        check("oor_data", 64'(data_out), 64'h0);
        check("oor_valid", 64'(valid_out), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
        check("oor_selerr", 64'(sel_err), 64'h1);
`endif

        // Idle then valid zero data
        drive(1'b0, 4'hA, 4'd5);
        step();
        check("idle_data", 64'(data_out), 64'h0);
        check("idle_valid", 64'(valid_out), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
        check("idle_selerr", 64'(sel_err), 64'h0);
`endif
        drive(1'b1, 4'h0, 4'd5);
        step();
        check("zero_data", 64'(data_out), 64'h0);
        check("zero_valid", 64'(valid_out), 64'h0020);

        // Invalid out-of-range select raises nothing
        drive(1'b0, 4'hA, 4'd15);
        step();
        check("ioor_valid", 64'(valid_out), 64'h0);
`ifdef DEMUX_SEL_ERR_EN
        check("ioor_selerr", 64'(sel_err), 64'h0);
`endif

        // Async reset between edges while slot 9 holds 4'hA
        drive(1'b1, 4'hA, 4'd9);
        step();
        check("pre_data", 64'(data_out), 64'h0000_00A0_0000_0000);
        check("pre_valid", 64'(valid_out), 64'h0200);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_data", 64'(data_out), 64'h0);
        check("async_valid", 64'(valid_out), 64'h0);
        step();
        check("hold_valid", 64'(valid_out), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h3, 4'd1);
        step();
        check("post_data", 64'(data_out), 64'h0000_0000_0000_0030);
        check("post_valid", 64'(valid_out), 64'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
